mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single physical-memory port between instruction fetch (IF) and the load/store unit (LSU) of the RV64 core. It accepts one transaction at a time, latches it, and drives it onto the memory port with a ready/valid handshake. It returns read data or write completion to the requester that owns the transaction. It sits between the core's fetch/LSU logic and the pmem DPI bridge.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/mem_arb_if.sv | 61 ++++++
 rtl/mem_arb_pick.sv | 47 ++++
 rtl/mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and default widths for the IF/LSU memory
//                arbiter (FSM state encoding, transaction owner encoding).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_W_DEFAULT = 64;
    localparam int DATA_W_DEFAULT = 64;

    // Arbiter transaction phases
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    // Which requester owns the transaction in flight
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

endpackage
`default_nettype wire

// File: rtl/mem_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_if
//  Description : Bundle of the IF request port, LSU request port and the
//                shared memory port. 'slave' is the arbiter view, 'master'
//                is the view of whoever drives requests and memory responses.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arb_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEFAULT,
    parameter int DATA_W = mem_arb_pkg::DATA_W_DEFAULT
);
    localparam int MASK_W = DATA_W / 8;

    // Instruction fetch port (read only)
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    // Load/store port
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic [MASK_W-1:0] ls_wmask;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    // Physical memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_wmask,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_wmask,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rvalid, mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pick
//  Description : Combinational winner select between IF and LSU requests.
//                Build option MEM_ARB_RR_EN: when defined, simultaneous
//                requests alternate using the last-owner pointer; when
//                undefined, the LSU always wins a tie.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req_i,
    input  logic   ls_req_i,
    input  owner_e last_owner_i,
    output logic   any_req_o,
    output owner_e winner_o
);

    assign any_req_o = if_req_i | ls_req_i;

`ifdef MEM_ARB_RR_EN
    // Round-robin: a sole requester wins, a tie goes to whoever lost last time
    always_comb begin
        winner_o = OWN_IF;
        if (ls_req_i && if_req_i) begin
            winner_o = (last_owner_i == OWN_LS) ? OWN_IF : OWN_LS;
        end else if (ls_req_i) begin
            winner_o = OWN_LS;
        end
    end
`else
    // The pointer carries no weight under fixed priority
    logic w_unused_ptr;
    assign w_unused_ptr = (last_owner_i == OWN_LS);

    // Fixed priority: the LSU wins any tie so stores/loads are never starved
    always_comb begin
        winner_o = OWN_IF;
        if (ls_req_i) begin
            winner_o = OWN_LS;
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one memory port between instruction fetch and the
//                load/store unit. One transaction in flight at a time:
//                grant/latch in IDLE, present on the memory port in REQ,
//                wait for the response in WAIT, return it to the owner from
//                RESP. Build option MEM_ARB_RR_EN selects round-robin tie
//                breaking (see mem_arb_pick); default is LSU-first priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic     clk,
    input  logic     rst_n,
    mem_arb_if.slave bus
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [DATA_W-1:0] resp_q, resp_d;
    logic              if_gnt_q, if_gnt_d;
    logic              ls_gnt_q, ls_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    logic   any_req;
    owner_e winner;

    mem_arb_pick u_pick (
        .if_req_i     (bus.if_req),
        .ls_req_i     (bus.ls_req),
        .last_owner_i (last_q),
        .any_req_o    (any_req),
        .winner_o     (winner)
    );

    // State register; reset drops any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Phase sequencing: one grant, one memory handshake, one response
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req)         state_d = REQ;
            REQ:     if (bus.mem_ready)   state_d = WAIT;
            WAIT:    if (bus.mem_rvalid)  state_d = RESP;
            RESP:                         state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Next values for the latched transaction, grant pulses and response return
    always_comb begin
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        resp_d      = resp_q;
        if_gnt_d    = 1'b0;
        ls_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = winner;
                    last_d  = winner;
                    if (winner == OWN_LS) begin
                        we_d     = bus.ls_we;
                        addr_d   = bus.ls_addr;
                        wdata_d  = bus.ls_wdata;
                        wmask_d  = bus.ls_wmask;
                        ls_gnt_d = 1'b1;
                    end else begin
                        // Fetch is read-only: never let stale LSU write fields leak out
                        we_d     = 1'b0;
                        addr_d   = bus.if_addr;
                        wdata_d  = '0;
                        wmask_d  = '0;
                        if_gnt_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    // A write completion carries no data back to the LSU
                    resp_d = we_q ? '0 : bus.mem_rdata;
                end
            end
            RESP: begin
                if (owner_q == OWN_LS) begin
                    ls_rvalid_d = 1'b1;
                    ls_rdata_d  = resp_q;
                end else begin
                    if_rvalid_d = 1'b1;
                    if_rdata_d  = resp_q;
                end
            end
            default: ;
        endcase
    end

    // Transaction latches and registered requester-side outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= OWN_IF;
            last_q      <= OWN_IF;   // makes the LSU the first tie winner
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            resp_q      <= '0;
            if_gnt_q    <= 1'b0;
            ls_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            owner_q     <= owner_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            resp_q      <= resp_d;
            if_gnt_q    <= if_gnt_d;
            ls_gnt_q    <= ls_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    // Memory fields come straight from the latches so they hold during a stall
    assign bus.mem_req   = (state_q == REQ);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wmask = wmask_q;

    assign bus.if_gnt    = if_gnt_q;
    assign bus.ls_gnt    = ls_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.ls_rvalid = ls_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: vector table of single
//                transactions, scoreboard of expected responses, plus stall,
//                contention, reset-in-WAIT and spurious-response sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arb_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        is_ls;
        logic [63:0] rdata;
    } sb_t;
    sb_t  sb_q[$];
    logic gnt_log[$];

    task automatic sb_push(input logic is_ls, input logic [63:0] d);
        sb_t e;
        e.is_ls = is_ls;
        e.rdata = d;
        sb_q.push_back(e);
    endtask

    // ---------------- memory model ----------------
    function automatic logic [63:0] mem_model(input logic [63:0] a);
        if (a == 64'h8000_0000) return 64'h0010_0073;
        return {~a[31:0], a[31:0]};
    endfunction

    bit          mem_auto = 1'b1;
    int          stall_cycles = 0;
    int          stall_cnt = 0;
    bit          rsp_pend = 1'b0;
    logic [63:0] rsp_data = '0;
    logic        man_ready = 1'b0;
    logic        man_rvalid = 1'b0;
    logic [63:0] man_rdata = '0;

    // Responder: accepts after stall_cycles, answers in the first WAIT cycle
    initial begin
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (mem_auto) begin
                bus.mem_ready  = 1'b0;
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = '0;
                if (rsp_pend) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rsp_data;
                    rsp_pend       = 1'b0;
                end
                if (bus.mem_req) begin
                    if (stall_cnt < stall_cycles) begin
                        stall_cnt++;
                    end else begin
                        bus.mem_ready = 1'b1;
                        stall_cnt     = 0;
                        rsp_pend      = 1'b1;
                        rsp_data      = bus.mem_we ? 64'hBAD0_BAD0_BAD0_BAD0 : mem_model(bus.mem_addr);
                    end
                end
            end else begin
                rsp_pend       = 1'b0;
                stall_cnt      = 0;
                bus.mem_ready  = man_ready;
                bus.mem_rvalid = man_rvalid;
                bus.mem_rdata  = man_rdata;
            end
        end
    end

    // Monitor: pops the scoreboard on every rvalid, logs grants
    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            if (bus.ls_gnt) gnt_log.push_back(1'b1);
            if (bus.if_gnt) gnt_log.push_back(1'b0);
            if (bus.if_rvalid || bus.ls_rvalid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rvalid", {bus.ls_rvalid, bus.if_rvalid}, 2'b00);
                end else begin
                    e = sb_q.pop_front();
                    check("rvalid_owner", {bus.ls_rvalid, bus.if_rvalid}, e.is_ls ? 2'b10 : 2'b01);
                    check("rdata", e.is_ls ? bus.ls_rdata : bus.if_rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic        is_ls;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        int          stall;
        logic        exp_we;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_wmask;
        logic [63:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {bus.if_gnt, bus.if_rvalid, bus.ls_gnt, bus.ls_rvalid, bus.mem_req, bus.mem_we}, 6'b0);
        check({tag, "_if_rdata"}, bus.if_rdata, 64'h0);
        check({tag, "_ls_rdata"}, bus.ls_rdata, 64'h0);
        check({tag, "_mem_addr"}, bus.mem_addr, 64'h0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 64'h0);
        check({tag, "_mem_wmask"}, {56'h0, bus.mem_wmask}, 64'h0);
    endtask

    // Called on a negedge with the DUT idle
    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        bit done;
        stall_cycles = v.stall;
        bus.ls_we    = v.we;
        bus.ls_addr  = v.addr;
        bus.ls_wdata = v.wdata;
        bus.ls_wmask = v.wmask;
        bus.if_addr  = v.addr;
        if (v.is_ls) bus.ls_req = 1'b1;
        else         bus.if_req = 1'b1;
        sb_push(v.is_ls, v.exp_rdata);
        @(negedge clk);
        check($sformatf("v%0d_gnt", idx), {bus.ls_gnt, bus.if_gnt}, v.is_ls ? 2'b10 : 2'b01);
        check($sformatf("v%0d_mem_req", idx), bus.mem_req, 1'b1);
        check($sformatf("v%0d_mem_we", idx), bus.mem_we, v.exp_we);
        check($sformatf("v%0d_mem_addr", idx), bus.mem_addr, v.addr);
        check($sformatf("v%0d_mem_wdata", idx), bus.mem_wdata, v.exp_wdata);
        check($sformatf("v%0d_mem_wmask", idx), {56'h0, bus.mem_wmask}, {56'h0, v.exp_wmask});
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        lat  = 1;
        done = 1'b0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.if_rvalid || bus.ls_rvalid) done = 1'b1;
        end
        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    endtask

    task automatic wait_sb_empty(input string name);
        int c;
        c = 0;
        while (sb_q.size() != 0 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check(name, sb_q.size(), 0);
    endtask

    vec_t vecs[6];
    logic exp_order[4];
    int   ls_n, if_n, pulses;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 64'h8000_0000, 64'h1111, 8'hFF, 0, 1'b0, 64'h0,    8'h00, 64'h0000_0000_0010_0073, 4};
        vecs[1] = '{1'b1, 1'b1, 64'h8000_1000, 64'hDEAD_BEEF, 8'hFF, 0, 1'b1, 64'hDEAD_BEEF, 8'hFF, 64'h0, 4};
        vecs[2] = '{1'b1, 1'b0, 64'h8000_1008, 64'h55,   8'h00, 2, 1'b0, 64'h55,   8'h00, 64'h7FFF_EFF7_8000_1008, 6};
        vecs[3] = '{1'b0, 1'b0, 64'h8000_0004, 64'h2222, 8'h0F, 1, 1'b0, 64'h0,    8'h00, 64'h7FFF_FFFB_8000_0004, 5};
        vecs[4] = '{1'b1, 1'b0, 64'h8000_0000, 64'h0,    8'h00, 0, 1'b0, 64'h0,    8'h00, 64'h0000_0000_0010_0073, 4};
        vecs[5] = '{1'b1, 1'b1, 64'h8000_2010, 64'h0123_4567_89AB_CDEF, 8'h0F, 3, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h0F, 64'h0, 7};

        rst_n        = 1'b0;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.ls_req   = 1'b0;
        bus.ls_we    = 1'b0;
        bus.ls_addr  = '0;
        bus.ls_wdata = '0;
        bus.ls_wmask = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single-requester transactions
        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);
        wait_sb_empty("vec_drain");
        check("if_rdata_hold", bus.if_rdata, 64'h7FFF_FFFB_8000_0004);
        check("ls_rdata_write_zero", bus.ls_rdata, 64'h0);

        // Stall in REQ with IF arriving meanwhile
        stall_cycles = 5;
        bus.ls_we    = 1'b1;
        bus.ls_addr  = 64'h8000_3000;
        bus.ls_wdata = 64'hCAFE_F00D;
        bus.ls_wmask = 8'hF0;
        bus.ls_req   = 1'b1;
        sb_push(1'b1, 64'h0);
        @(negedge clk);
        check("stall_gnt", {bus.ls_gnt, bus.if_gnt}, 2'b10);
        bus.ls_req  = 1'b0;
        bus.if_addr = 64'h8000_0008;
        bus.if_req  = 1'b1;
        sb_push(1'b0, 64'h7FFF_FFF7_8000_0008);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_mem_req", bus.mem_req, 1'b1);
            check("stall_mem_we", bus.mem_we, 1'b1);
            check("stall_mem_addr", bus.mem_addr, 64'h8000_3000);
            check("stall_mem_wdata", bus.mem_wdata, 64'hCAFE_F00D);
            check("stall_mem_wmask", {56'h0, bus.mem_wmask}, 64'hF0);
            check("stall_no_if_gnt", bus.if_gnt, 1'b0);
        end
        stall_cycles = 0;
        begin
            int c;
            c = 0;
            while (!bus.if_gnt && c < 50) begin
                @(negedge clk);
                c++;
            end
            check("stall_if_gnt_seen", bus.if_gnt, 1'b1);
        end
        bus.if_req = 1'b0;
        wait_sb_empty("stall_drain");

        // Contention: LSU quota 3, IF quota 1
`ifdef MEM_ARB_RR_EN
        exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1; exp_order[3] = 1'b1;
`else
        exp_order[0] = 1'b1; exp_order[1] = 1'b1; exp_order[2] = 1'b1; exp_order[3] = 1'b0;
`endif
        for (int i = 0; i < 4; i++)
            sb_push(exp_order[i], exp_order[i] ? 64'h7FFF_AFFF_8000_5000 : 64'h7FFF_BFFF_8000_4000);
        gnt_log.delete();
        bus.ls_we   = 1'b0;
        bus.ls_addr = 64'h8000_5000;
        bus.if_addr = 64'h8000_4000;
        bus.ls_req  = 1'b1;
        bus.if_req  = 1'b1;
        ls_n = 0;
        if_n = 0;
        for (int c = 0; c < 200 && sb_q.size() != 0; c++) begin
            @(negedge clk);
            if (bus.ls_gnt) begin
                ls_n++;
                if (ls_n == 3) bus.ls_req = 1'b0;
            end
            if (bus.if_gnt) begin
                if_n++;
                bus.if_req = 1'b0;
            end
        end
        bus.ls_req = 1'b0;
        bus.if_req = 1'b0;
        check("contention_drained", sb_q.size(), 0);
        check("contention_gnt_count", gnt_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < gnt_log.size())
                check($sformatf("contention_gnt%0d", i), gnt_log[i], exp_order[i]);

        // Reset while waiting for the memory response
        @(negedge clk);
        man_ready  = 1'b0;
        man_rvalid = 1'b0;
        mem_auto   = 1'b0;
        @(negedge clk);
        bus.ls_we   = 1'b0;
        bus.ls_addr = 64'h8000_6000;
        bus.ls_req  = 1'b1;
        @(negedge clk);
        check("rst_txn_gnt", bus.ls_gnt, 1'b1);
        bus.ls_req = 1'b0;
        man_ready  = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
        check("rst_txn_in_wait", bus.mem_req, 1'b0);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst_n      = 1'b1;
        man_rvalid = 1'b1;
        man_rdata  = 64'hFEED_FACE;
        @(negedge clk);
        man_rvalid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.if_rvalid || bus.ls_rvalid || bus.mem_req) pulses++;
        end
        check("post_reset_quiet", pulses, 0);
        check_all_zero("post_reset");

        // Spurious response while idle
        man_rvalid = 1'b1;
        man_rdata  = 64'hABCD;
        repeat (2) @(negedge clk);
        man_rvalid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.if_rvalid || bus.ls_rvalid || bus.mem_req) pulses++;
        end
        check("spurious_ignored", pulses, 0);
        check("spurious_if_rdata", bus.if_rdata, 64'h0);
        mem_auto = 1'b1;
        @(negedge clk);
        run_vec(6, vecs[0]);
        wait_sb_empty("final_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
